// File: rtl/tk1_uds_pkg.sv
// Shared definitions for the UDS fetch sequencer: state encoding, store geometry
// and a small state-classification helper.
package tk1_uds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_LOCKED = 2'd3
  } uds_state_e;

  localparam int UDS_WORDS  = 8;
  localparam int UDS_ADDR_W = 3;
  localparam int UDS_TMO_W  = 8;

  function automatic logic state_busy(input uds_state_e st);
    return (st == ST_READ) || (st == ST_HOLD);
  endfunction

endpackage

// File: rtl/uds_fetch_ctrl.sv
// Read-once UDS fetch sequencer: streams each UDS word to the key-derivation
// datapath, wipes the holding register after every handoff and locks until reset.
module uds_fetch_ctrl
  import tk1_uds_pkg::*;
#(
  parameter int NUM_WORDS      = UDS_WORDS,
  parameter int ADDR_WIDTH     = UDS_ADDR_W,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  app_mode,
  output logic                  uds_cs,
  output logic                  uds_en,
  output logic [ADDR_WIDTH-1:0] uds_address,
  input  logic [31:0]           uds_read_data,
  input  logic                  uds_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = ADDR_WIDTH'(1'b0);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1'b1);
  localparam logic [UDS_TMO_W-1:0]  TMO_LAST = UDS_TMO_W'(TIMEOUT_CYCLES - 1);

  uds_state_e            state_r, state_s;
  logic [ADDR_WIDTH-1:0] index_r, index_s;
  logic [UDS_TMO_W-1:0]  tmo_cnt_r, tmo_cnt_s;
  logic [31:0]           data_r, data_s;
  logic                  done_r, done_s;
  logic                  error_r, error_s;

  logic                  uds_cs_r, uds_cs_s;
  logic [ADDR_WIDTH-1:0] uds_address_r, uds_address_s;
  logic                  out_valid_r, out_valid_s;
  logic [31:0]           out_data_r, out_data_s;
  logic [ADDR_WIDTH-1:0] out_index_r, out_index_s;
  logic                  out_last_r, out_last_s;
  logic                  busy_r, busy_s;

  // Next-state decode plus next-output decode, so every port comes straight from a flop.
  always_comb begin
    state_s   = state_r;
    index_s   = index_r;
    tmo_cnt_s = tmo_cnt_r;
    data_s    = data_r;
    done_s    = done_r;
    error_s   = error_r;

    case (state_r)
      ST_IDLE: begin
        if (start && app_mode) begin
          state_s = ST_LOCKED;
          error_s = 1'b1;
        end else if (start) begin
          state_s   = ST_READ;
          index_s   = IDX_ZERO;
          tmo_cnt_s = 8'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        // An application-mode switch beats a completing access: the word is never captured.
        if (app_mode) begin
          state_s = ST_LOCKED;
          error_s = 1'b1;
          data_s  = 32'd0;
        end else if (uds_ready) begin
          state_s = ST_HOLD;
          data_s  = uds_read_data;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_s = ST_LOCKED;
          error_s = 1'b1;
        end else begin
          tmo_cnt_s = tmo_cnt_r + 8'd1;
        end
      end
      ST_HOLD: begin
        if (app_mode) begin
          state_s = ST_LOCKED;
          error_s = 1'b1;
          data_s  = 32'd0;
        end else if (out_ready) begin
          data_s = 32'd0;
          if (index_r == LAST_IDX) begin
            state_s = ST_LOCKED;
            done_s  = 1'b1;
          end else begin
            state_s   = ST_READ;
            index_s   = index_r + IDX_ONE;
            tmo_cnt_s = 8'd0;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_LOCKED: begin
        state_s = ST_LOCKED;
      end
      default: begin
        state_s = ST_LOCKED;
        error_s = 1'b1;
        data_s  = 32'd0;
      end
    endcase

    uds_cs_s      = (state_s == ST_READ);
    uds_address_s = uds_cs_s ? index_s : IDX_ZERO;
    out_valid_s   = (state_s == ST_HOLD);
    out_data_s    = out_valid_s ? data_s : 32'd0;
    out_index_s   = out_valid_s ? index_s : IDX_ZERO;
    out_last_s    = out_valid_s && (index_s == LAST_IDX);
    busy_s        = state_busy(state_s);
  end

  // State, counters, holding register and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      index_r       <= IDX_ZERO;
      tmo_cnt_r     <= 8'd0;
      data_r        <= 32'd0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
      uds_cs_r      <= 1'b0;
      uds_address_r <= IDX_ZERO;
      out_valid_r   <= 1'b0;
      out_data_r    <= 32'd0;
      out_index_r   <= IDX_ZERO;
      out_last_r    <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      index_r       <= index_s;
      tmo_cnt_r     <= tmo_cnt_s;
      data_r        <= data_s;
      done_r        <= done_s;
      error_r       <= error_s;
      uds_cs_r      <= uds_cs_s;
      uds_address_r <= uds_address_s;
      out_valid_r   <= out_valid_s;
      out_data_r    <= out_data_s;
      out_index_r   <= out_index_s;
      out_last_r    <= out_last_s;
      busy_r        <= busy_s;
    end
  end

  assign uds_cs      = uds_cs_r;
  assign uds_en      = uds_cs_r;
  assign uds_address = uds_address_r;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_index   = out_index_r;
  assign out_last    = out_last_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign error       = error_r;

endmodule

// File: tb/tb_uds_fetch_ctrl.sv
// Randomized scoreboard bench for uds_fetch_ctrl: a UDS store model, a consumer
// with backpressure, and a monitor comparing handed-off words against expectations.
module tb_uds_fetch_ctrl;
  import tk1_uds_pkg::*;

  localparam int NW  = 8;
  localparam int AW  = 3;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          reset_n, start, app_mode;
  logic          uds_cs, uds_en, uds_ready;
  logic [AW-1:0] uds_address;
  logic [31:0]   uds_read_data;
  logic          out_valid, out_ready, out_last, busy, done, error;
  logic [31:0]   out_data;
  logic [AW-1:0] out_index;

  always #5 clk = ~clk;

  uds_fetch_ctrl #(.NUM_WORDS(NW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .app_mode(app_mode),
    .uds_cs(uds_cs), .uds_en(uds_en), .uds_address(uds_address),
    .uds_read_data(uds_read_data), .uds_ready(uds_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done), .error(error)
  );

  typedef struct {
    logic [31:0] data;
    int          idx;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [NW];
  int          n_vec = 0;
  int          n_err = 0;

  bit  fast, acc_active, mon_en;
  int  stall_word, stall_left, stuck_addr, wait_left;
  int  fetch_cnt, handoffs, cs_tot, cs_stuck;
  bit  prev_stall;
  logic [31:0]   prev_data;
  logic [AW-1:0] prev_idx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // One clock: UDS store model and consumer react to the DUT just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (uds_cs) begin
      if (!acc_active) begin
        acc_active = 1'b1;
        if (int'(uds_address) == stuck_addr) wait_left = 1000;
        else if (fast) wait_left = 0;
        else wait_left = int'($urandom_range(0, 4));
      end
      if (wait_left == 0) begin
        uds_ready     = 1'b1;
        uds_read_data = mem[uds_address];
        acc_active    = 1'b0;
      end else begin
        uds_ready     = 1'b0;
        uds_read_data = $urandom;
        wait_left--;
      end
    end else begin
      acc_active    = 1'b0;
      uds_ready     = 1'($urandom_range(0, 1));
      uds_read_data = $urandom;
    end
    if (out_valid && int'(out_index) == stall_word && stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if (fast) begin
      out_ready = 1'b1;
    end else begin
      out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on each accepted handoff.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("uds_en_follows_cs", uds_en, uds_cs);
      chk("bus_idle_in_hold", out_valid & uds_cs, 0);
      chk("done_error_exclusive", done & error, 0);
      if (!out_valid) chk("out_data_zero_when_invalid", out_data, 0);
      if (out_valid) chk("out_last_flag", out_last, out_index == AW'(NW - 1));
      if (uds_cs) begin
        cs_tot++;
        if (int'(uds_address) == stuck_addr) cs_stuck++;
        chk("uds_address_order", uds_address, fetch_cnt);
      end
      if (prev_stall) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_data_stable", out_data, prev_data);
        chk("stall_index_stable", out_index, prev_idx);
      end
      if (reset_n && !app_mode) begin
        if (uds_cs && uds_ready) fetch_cnt++;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_handoff", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("handoff_data", out_data, e.data);
            chk("handoff_index", out_index, e.idx);
            chk("handoff_last", out_last, e.idx == NW - 1);
            handoffs++;
          end
        end
      end
      prev_stall = out_valid && !out_ready && !app_mode && reset_n;
      prev_data  = out_data;
      prev_idx   = out_index;
    end
  end

  task automatic clear_tracking();
    exp_q.delete();
    fetch_cnt  = 0;
    handoffs   = 0;
    cs_tot     = 0;
    cs_stuck   = 0;
    prev_stall = 1'b0;
    acc_active = 1'b0;
    stall_word = -1;
    stall_left = 0;
    stuck_addr = NW;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    app_mode = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    clear_tracking();
  endtask

  task automatic randomize_mem();
    for (int a = 0; a < NW; a++) mem[a] = $urandom;
  endtask

  // Reference model: a run hands off words 0..k-1, where k is the first word at
  // which an abort or a stuck access intervenes; done only if all words went out.
  task automatic do_run(input bit f, input int sw, input int sl, input int ab_word,
                        input int ab_phase, input int stuck, output int lat);
    int  k;
    int  n;
    int  cs_snap;
    bit  aborted;
    fast       = f;
    stall_word = sw;
    stall_left = sl;
    stuck_addr = stuck;
    k = NW;
    if (ab_word < k) k = ab_word;
    if (stuck < k) k = stuck;
    for (int w = 0; w < k; w++) exp_q.push_back('{mem[w], w});
    start = 1'b1;
    step();
    start   = 1'b0;
    aborted = 1'b0;
    n       = 0;
    while (!(done || error) && n < 500) begin
      step();
      n++;
      if (!aborted && ab_word < NW &&
          ((ab_phase == 0 && out_valid && int'(out_index) == ab_word) ||
           (ab_phase == 1 && uds_cs && int'(uds_address) == ab_word))) begin
        app_mode  = 1'b1;
        out_ready = 1'b1;
        aborted   = 1'b1;
      end
    end
    lat = n;
    chk("run_terminates", n < 500, 1);
    if (aborted) begin
      chk("abort_no_valid", out_valid, 0);
      chk("abort_data_zero", out_data, 0);
    end
    repeat (3) step();
    chk("final_done", done, k == NW);
    chk("final_error", error, k != NW);
    chk("final_not_busy", busy, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("handoff_count", handoffs, k);
    if (stuck < NW && stuck < ab_word) chk("timeout_cs_cycles", cs_stuck, TMO);
    cs_snap  = cs_tot;
    app_mode = 1'b0;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("locked_no_bus", cs_tot, cs_snap);
    chk("locked_done_kept", done, k == NW);
    chk("locked_error_kept", error, k != NW);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n;
    int r;
    int ab;
    int st;
    reset_n       = 1'b0;
    start         = 1'b0;
    app_mode      = 1'b0;
    uds_ready     = 1'b0;
    uds_read_data = 32'd0;
    out_ready     = 1'b0;
    fast          = 1'b1;
    mon_en        = 1'b0;
    clear_tracking();
    do_reset();
    mon_en = 1'b1;
    chk("reset_outputs", {uds_cs, uds_en, uds_address, out_valid, out_data, out_index,
                          out_last, busy, done, error}, 64'd0);

    // Normal run with the fixed pattern and the two-cycle-per-word latency.
    for (int a = 0; a < NW; a++) mem[a] = 32'hA5A5_0000 + a;
    do_run(1'b1, -1, 0, NW, 0, NW, lat);
    chk("done_latency_cycles", lat, 16);

    // Backpressure on word 3.
    do_reset();
    randomize_mem();
    do_run(1'b1, 3, 5, NW, 0, NW, lat);

    // Abort in HOLD of word 2 with out_ready high in the same cycle.
    do_reset();
    randomize_mem();
    do_run(1'b1, -1, 0, 2, 0, NW, lat);

    // Stuck access on word 5.
    do_reset();
    randomize_mem();
    do_run(1'b0, -1, 0, NW, 0, 5, lat);

    // Start while in application mode.
    do_reset();
    app_mode = 1'b1;
    start    = 1'b1;
    step();
    start    = 1'b0;
    app_mode = 1'b0;
    repeat (4) step();
    chk("appmode_start_error", error, 1);
    chk("appmode_start_done", done, 0);
    chk("appmode_start_busy", busy, 0);
    chk("appmode_start_no_bus", cs_tot, 0);

    // Reset mid-run after four words, then a fresh full fetch.
    do_reset();
    randomize_mem();
    fast = 1'b1;
    for (int w = 0; w < NW; w++) exp_q.push_back('{mem[w], w});
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (handoffs < 4 && n < 200) begin
      step();
      n++;
    end
    chk("midrun_reached_word4", handoffs, 4);
    reset_n = 1'b0;
    step();
    chk("midrun_reset_outputs", {uds_cs, uds_en, uds_address, out_valid, out_data, out_index,
                                 out_last, busy, done, error}, 64'd0);
    clear_tracking();
    reset_n = 1'b1;
    step();
    do_run(1'b1, -1, 0, NW, 0, NW, lat);

    // Randomized runs: normal, abort, or timeout with random stalls and latencies.
    for (int it = 0; it < 25; it++) begin
      do_reset();
      randomize_mem();
      r  = int'($urandom_range(0, 2));
      ab = (r == 1) ? int'($urandom_range(0, NW - 1)) : NW;
      st = (r == 2) ? int'($urandom_range(0, NW - 1)) : NW;
      do_run(1'($urandom_range(0, 1)), int'($urandom_range(0, NW - 1)),
             int'($urandom_range(0, 6)), ab, int'($urandom_range(0, 1)), st, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
